// File: rtl/arb_pkg.sv
// Shared constants, state encoding and the rotating priority search
// used by the 16-way round-robin grant arbiter.
package arb_pkg;

  localparam int N    = 16;
  localparam int IDXW = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } pick_t;

  // Walk downward from ptr (ptr, ptr-1, ..., 0, N-1, ..., ptr+1) and
  // return the first requester found; the 4-bit subtraction provides the wrap.
  function automatic pick_t rotating_pick(input logic [N-1:0]    req,
                                          input logic [IDXW-1:0] ptr);
    pick_t           res;
    logic [IDXW-1:0] cand;
    res = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr - IDXW'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_enc16.sv
// Rotated highest-index-first priority encoder over 16 requests.
module rr_prio_enc16
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  pick_t pick;

  // Pure combinational search starting at ptr and moving downward.
  always_comb begin
    pick  = rotating_pick(req, ptr);
    idx   = pick.idx;
    found = pick.found;
  end

endmodule

// File: rtl/rr_grant_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
// A grant is registered one cycle after the sampled request and held
// until the owner releases it (done, dropped request or hold timeout).
//
//   state | meaning
//   IDLE  | no grant active; arbitrate when en=1 and any req is set
//   BUSY  | grant held on gnt_idx; wait for a release condition
module rr_grant_arbiter_16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

  // Hold counter sized for MAX_HOLD; at least one bit when the timeout is off.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_TC  = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
  localparam logic [HCW-1:0] HOLD_SAT = '1;

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] idx_q, idx_nxt;
  logic [HCW-1:0]  hold_cnt, hold_nxt;

  logic [IDXW-1:0] pick_idx;
  logic            pick_found;
  logic            release_c;

  rr_prio_enc16 u_enc (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Release when the owner is done, drops its request, or times out.
  always_comb begin
    release_c = done || !req[idx_q] ||
                ((MAX_HOLD != 0) && (hold_cnt == HOLD_TC));
  end

  // State register plus grant datapath registers; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDXW'(N - 1);
      idx_q    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      idx_q    <= idx_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic: grant in IDLE, hold/release in BUSY. No new grant is
  // taken on the release edge, which produces the single idle bubble.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx_q;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (en && pick_found) begin
          state_nxt = BUSY;
          idx_nxt   = pick_idx;
          ptr_nxt   = pick_idx - IDXW'(1);
          hold_nxt  = '0;
        end
      end
      BUSY: begin
        if (release_c) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nxt = hold_cnt + HCW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs decode purely from registers, so they change only on clock/reset.
  always_comb begin
    gnt_vld = (state == BUSY);
    gnt_idx = idx_q;
    gnt     = '0;
    if (gnt_vld) gnt[idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_rr_grant_arbiter_16.sv
// Directed-vector bench for rr_grant_arbiter_16 with a scoreboard queue.
module tb_rr_grant_arbiter_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, done_a, en_b, done_b;
  logic [15:0] req_a, req_b;
  logic [15:0] gnt_a, gnt_b;
  logic [3:0]  idx_a, idx_b;
  logic        vld_a, vld_b;

  typedef struct packed {
    logic        sel_b;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  event  chk_ev;

  always #5 clk = ~clk;

  rr_grant_arbiter_16 #(.MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a)
  );

  rr_grant_arbiter_16 #(.MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b)
  );

  task automatic push(input bit sel_b, input bit vld, input int idx, input string nm);
    exp_t e;
    e.sel_b = sel_b;
    e.vld   = vld;
    e.idx   = vld ? 4'(idx) : 4'd0;
    e.gnt   = vld ? (16'd1 << idx) : 16'd0;
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Monitor: drain the scoreboard whenever outputs are sampled.
  always begin
    @(negedge clk or chk_ev);
    while (q_exp.size() > 0) begin
      exp_t  e;
      string nm;
      logic [15:0] ag;
      logic [3:0]  ai;
      logic        av;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      ag = e.sel_b ? gnt_b : gnt_a;
      ai = e.sel_b ? idx_b : idx_a;
      av = e.sel_b ? vld_b : vld_a;
      n_cmp++;
      if ({ag, ai, av} !== {e.gnt, e.idx, e.vld}) begin
        n_bad++;
        $display("FAIL %s: got gnt=%h idx=%0d vld=%b, expected gnt=%h idx=%0d vld=%b",
                 nm, ag, ai, av, e.gnt, e.idx, e.vld);
      end
    end
  end

  task automatic do_reset(input string nm);
    rst = 1'b1;
    push(1'b0, 1'b0, 0, {nm, "_a"});
    push(1'b1, 1'b0, 0, {nm, "_b"});
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cyc(input bit en, input logic [15:0] req, input bit done,
                     input bit vld, input int idx, input string nm);
    en_a = en; req_a = req; done_a = done;
    @(posedge clk);
    push(1'b0, vld, idx, nm);
    #1;
  endtask

  task automatic cycb(input bit en, input logic [15:0] req, input bit done,
                      input bit vld, input int idx, input string nm);
    en_b = en; req_b = req; done_b = done;
    @(posedge clk);
    push(1'b1, vld, idx, nm);
    #1;
  endtask

  initial begin
    en_a = 0; req_a = 0; done_a = 0;
    en_b = 0; req_b = 0; done_b = 0;
    do_reset("reset_state");

    // Fixed priority out of reset, then round robin with one bubble.
    cyc(1, 16'h8001, 0, 1, 15, "first_grant_15");
    cyc(1, 16'h8001, 1, 0, 0,  "done_bubble_1");
    cyc(1, 16'h8001, 0, 1, 0,  "rr_grant_0");
    cyc(1, 16'h8001, 1, 0, 0,  "done_bubble_2");
    cyc(1, 16'h8001, 0, 1, 15, "rr_grant_15_again");
    cyc(0, 16'h0000, 1, 0, 0,  "release_all");
    cyc(1, 16'h0000, 1, 0, 0,  "done_in_idle_ignored");

    // Full rotation with every requester active.
    do_reset("reset_before_sweep");
    for (int k = 15; k >= 0; k--) begin
      cyc(1, 16'hFFFF, 0, 1, k, $sformatf("sweep_grant_%0d", k));
      cyc(1, 16'hFFFF, 1, 0, 0, $sformatf("sweep_bubble_%0d", k));
    end
    cyc(1, 16'hFFFF, 0, 1, 15, "sweep_wrap_15");
    cyc(0, 16'h0000, 1, 0, 0,  "sweep_release");

    // Hold timeout on the MAX_HOLD=4 instance.
    for (int c = 0; c < 4; c++)
      cycb(1, 16'h0010, 0, 1, 4, $sformatf("timeout_hold_c%0d", c));
    cycb(1, 16'h0010, 0, 0, 0, "timeout_bubble");
    cycb(1, 16'h0010, 0, 1, 4, "timeout_regrant_4");
    cycb(0, 16'h0000, 0, 0, 0, "timeout_req_drop");

    // en=0 does not preempt; no new grant while en=0.
    cyc(1, 16'h0008, 0, 1, 3, "grant_3");
    cyc(0, 16'h0008, 0, 1, 3, "en0_hold_3_a");
    cyc(0, 16'h0008, 0, 1, 3, "en0_hold_3_b");
    cyc(0, 16'h0000, 0, 0, 0, "req_drop_release");
    cyc(0, 16'h0100, 0, 0, 0, "en0_no_grant_a");
    cyc(0, 16'h0100, 0, 0, 0, "en0_no_grant_b");
    cyc(1, 16'h0100, 0, 1, 8, "en1_grant_8");

    // Asynchronous reset between clock edges while BUSY.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    push(1'b0, 1'b0, 0, "async_rst_immediate");
    -> chk_ev;
    #1 rst = 1'b0;
    cyc(1, 16'h0006, 0, 1, 2, "post_rst_grant_2");
    cyc(1, 16'h0006, 1, 0, 0, "post_rst_bubble");
    cyc(1, 16'h0006, 0, 1, 1, "post_rst_grant_1");

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter_16.md
Name: rr_grant_arbiter_16

Overview:
- Sequential round-robin arbiter that shares one 16-input resource among 16 requesters.
- Arbitration core is a rotating highest-index-first priority encode. A grant is registered and then held until the owner releases it.
- Sits between requester blocks and the shared datapath. It drives the datapath select with a 4-bit index plus a valid flag.

Parameters:
- N, 16, number of requesters (fixed at 16 for this revision)
- IDXW, 4, width of the encoded grant index
- MAX_HOLD, 0, max cycles one grant may be held; 0 disables the timeout

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; gates new grants only
- req  input  16  request vector, bit k = requester k
- done  input  1  owner finished; releases current grant
- gnt  output  16  one-hot grant, registered
- gnt_idx  output  4  binary index of granted requester, registered
- gnt_vld  output  1  a grant is active, registered

Behaviour:
- Reset (async, immediate, also mid-grant):
  - gnt=0, gnt_idx=0, gnt_vld=0
  - state=IDLE, ptr=15, hold_cnt=0
  - Outputs never drive Z.
- States: IDLE, BUSY.
- Search order from ptr: ptr, ptr-1, ..., 0, 15, ..., ptr+1 (mod 16). The first set req bit wins.
  - With ptr=15 this reduces to fixed priority, bit 15 highest.
- IDLE:
  - If en=1 and req!=0 at a clk edge: winner w is registered. gnt=1<<w, gnt_idx=w, gnt_vld=1, ptr<=(w-1) mod 16, hold_cnt<=0, go to BUSY.
  - Latency is 1 cycle from sampled req to grant.
  - If en=0 or req=0: stay in IDLE, outputs 0.
- BUSY:
  - Grant held stable; gnt, gnt_idx and ptr do not change.
  - hold_cnt increments each cycle and saturates.
  - Release condition is any of:
    - done=1
    - req[gnt_idx]=0
    - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
  - On release edge: outputs go to 0, state goes to IDLE.
  - There is exactly one idle bubble cycle between successive grants. No back-to-back grant in the release cycle.
- en=0 during BUSY: no preemption; the current grant runs to release. No new grant is issued while en=0.
- Simultaneous done=1 and a new req from another requester: release first; the new requester is arbitrated in the following IDLE cycle.
- done=1 in IDLE is ignored.
- Wrap-around: w=0 gives ptr=15.
- Fairness: each requester that holds req continuously is granted within 16 grants.
- hold_cnt width is clog2(MAX_HOLD+1), minimum 1 bit.
- gnt is always one-hot or zero; gnt_vld equals |gnt.

Decomposition:
- Shared package arb_pkg:
  - constants N=16, IDXW=4
  - state typedef {IDLE, BUSY}
  - function rotating_pick(req, ptr) returning {found, idx}
- One natural combinational sub-module: rr_prio_enc16.
  - Inputs: req[15:0], ptr[3:0]. Outputs: idx[3:0], found.
  - Implements the rotated highest-index-first search.
  - Instanced once in the arbiter's IDLE path.

Test Plan:
- Reset, then en=1, req=16'h8001 -> next edge gnt=16'h8000, gnt_idx=15, gnt_vld=1; ptr becomes 14.
- From that state, done=1 for 1 cycle with req=16'h8001 held -> next edge outputs 0 (bubble); following edge gnt_idx=0; second grant after done has gnt_idx=15 again (round robin).
- req=16'hFFFF held, done pulsed each grant -> gnt_idx sequence 15,14,13,...,0,15 with one bubble between grants.
- MAX_HOLD=4, req=16'h0010 held, done=0 -> gnt_vld high exactly 4 cycles, then 1 bubble, then regranted idx=4.
- Grant active on idx=3, en=0, req[3] held -> grant stays; drop req[3] -> release next edge; req=16'h0100 with en=0 -> no grant until en=1, then gnt_idx=8 one cycle later.
- Assert rst asynchronously mid-BUSY (between clock edges) -> gnt=0, gnt_vld=0 immediately; after release with req=16'h0006 -> gnt_idx=2 (ptr back to 15).
